rsc_reg_xfer_ctrl: RTL
======================

Name: rsc_reg_xfer_ctrl

Overview:
Micro-sequencer sitting directly upstream of the RSC 4-entry register file. It accepts one register-transfer instruction at a time (MOV, ADDI, SUBI, CLR) over a valid/ready handshake. It then drives the register file's one-hot read enables, captures the read data, computes the result, and drives the one-hot write enables and write data. It guarantees that read and write enables never target the same register in the same cycle, and that at most one bit of each enable vector is set.

Parameters:
DATA_W, 16, register / bus data width
IMM_W, 8, immediate width; zero-extended to DATA_W

Ports:
clk  in  1  clock, rising-edge
rst  in  1  reset, synchronous, active-high
instr_valid  in  1  instruction present
instr_ready  out  1  block can accept an instruction
op  in  2  00 MOV rd<=rs, 01 ADDI rd<=rs+imm, 10 SUBI rd<=rs-imm, 11 CLR rd<=0
rd  in  2  destination register index
rs  in  2  source register index (ignored for CLR)
imm  in  IMM_W  immediate (ignored for MOV/CLR)
reg_rd_en  out  4  one-hot read enable to register file
reg_rd_data  in  DATA_W  register file read data
reg_wr_en  out  4  one-hot write enable to register file
reg_wr_data  out  DATA_W  write data to register file
done  out  1  one-cycle pulse, instruction retired
flag_z  out  1  zero flag (optional feature)
flag_c  out  1  carry/borrow flag (optional feature)

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; instr_ready=1; reg_rd_en=0000; reg_wr_en=0000; reg_wr_data=0; done=0; flag_z=0; flag_c=0; latched op/rd/rs/imm cleared. Reset mid-instruction aborts it with no write and no done pulse.
- FSM states: IDLE, READ, EXEC, WRITE. All outputs are registered or decoded from the state register; no combinational path from inputs to outputs except instr_ready, which equals (state==IDLE).
- IDLE: instr_ready=1. When instr_valid&instr_ready, latch op/rd/rs/imm. Next state is READ, or EXEC if op=CLR.
- READ (1 cycle): reg_rd_en=onehot(rs). Operand register captures reg_rd_data at the end of the cycle. reg_wr_en=0000. Next state: EXEC.
- EXEC (1 cycle): enables are 0000. Result computed in DATA_W+1 bits:
  - MOV: operand.
  - ADDI: operand + zext(imm); carry = bit DATA_W.
  - SUBI: operand - zext(imm), wrap-around modulo 2^DATA_W; borrow = 1 iff operand < zext(imm).
  - CLR: 0, carry 0.
  - Result is registered into reg_wr_data. Next state: WRITE.
- WRITE (1 cycle): reg_wr_en=onehot(rd); reg_rd_en=0000; done=1. Next state: IDLE.
- Latency: accept to done is 3 cycles (CLR: 2). Throughput is one instruction per 4 cycles (CLR: 3), since IDLE is always visited.
- rd==rs is legal: read and write occur in different cycles, so there is no enable conflict.
- instr_valid while not in IDLE is ignored; inputs are not held by the block.
- reg_wr_data holds its value outside WRITE. Only reg_wr_en qualifies a write.
- Invariant checked by the bench: reg_rd_en & reg_wr_en == 0000 every cycle, and each vector is 0 or one-hot.

Optional Feature:
Macro RSC_XFER_FLAGS_EN.
- Defined: flag_z and flag_c update on EXEC→WRITE and hold otherwise.
  - flag_z = (result[DATA_W-1:0]==0).
  - flag_c = carry (ADDI), borrow (SUBI), 0 (MOV/CLR).
- Undefined: the flag logic is omitted; flag_z and flag_c are tied 0. The ports remain so the interface is unchanged.

Decomposition:
- Shared package rsc_pkg holds:
  - op encodings OP_MOV/OP_ADDI/OP_SUBI/OP_CLR
  - FSM state typedef
  - one-hot constants ONEHOT_R0..R3 (0001, 0010, 0100, 1000) and ONEHOT_NONE
  - DATA_W default
- One sub-module: rsc_onehot_dec (2-bit index plus enable to 4-bit one-hot), instantiated for read and write enables.

Test Plan:
- Reset, then MOV rd=2 rs=0 with reg_rd_data=16'h1234 in READ → READ shows rd_en=0001; WRITE shows wr_en=0100, wr_data=1234; done 3 cycles after accept.
- ADDI rs=1 rd=1 imm=8'h01, reg_rd_data=16'hFFFF → wr_data=0000, wr_en=0010, flag_c=1, flag_z=1 (with RSC_XFER_FLAGS_EN).
- SUBI rs=3 rd=0 imm=8'h05, reg_rd_data=16'h0003 → wr_data=FFFE, flag_c=1, flag_z=0; without the macro, flags stay 0.
- CLR rd=3 → no rd_en pulse; wr_en=1000, wr_data=0000; done 2 cycles after accept; instr_ready low for exactly 2 cycles.
- Back-to-back instr_valid held high for 3 MOVs → accepts spaced 4 cycles apart; enable overlap invariant never violated.
- rst asserted during EXEC of ADDI → next cycle outputs are at reset values; no wr_en and no done for the aborted instruction.

Source files
------------

// File: rtl/rsc_pkg.sv
// Shared definitions for the RSC register-transfer controller slice.
//   - op encodings (OP_MOV/OP_ADDI/OP_SUBI/OP_CLR)
//   - controller FSM state type
//   - one-hot register-select constants
//   - default data / immediate widths
package rsc_pkg;

    localparam int unsigned DATA_W_DEFAULT = 16;
    localparam int unsigned IMM_W_DEFAULT  = 8;

    typedef enum logic [1:0] {
        OP_MOV  = 2'b00,
        OP_ADDI = 2'b01,
        OP_SUBI = 2'b10,
        OP_CLR  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StExec,
        StWrite
    } state_e;

    localparam logic [3:0] ONEHOT_NONE = 4'b0000;
    localparam logic [3:0] ONEHOT_R0   = 4'b0001;
    localparam logic [3:0] ONEHOT_R1   = 4'b0010;
    localparam logic [3:0] ONEHOT_R2   = 4'b0100;
    localparam logic [3:0] ONEHOT_R3   = 4'b1000;

endpackage

// File: rtl/rsc_reg_xfer_ctrl_if.sv
// Instruction handshake plus register-file bus of the RSC transfer controller.
//   instr_valid/instr_ready/op/rd/rs/imm : instruction channel
//   reg_rd_en/reg_rd_data                 : register-file read side
//   reg_wr_en/reg_wr_data                 : register-file write side
//   done/flag_z/flag_c                    : retire pulse and status flags
// Modports:
//   slave  : the controller
//   master : instruction source together with the register file it talks to
interface rsc_reg_xfer_ctrl_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned IMM_W  = 8
);
    logic              instr_valid;
    logic              instr_ready;
    logic [1:0]        op;
    logic [1:0]        rd;
    logic [1:0]        rs;
    logic [IMM_W-1:0]  imm;
    logic [3:0]        reg_rd_en;
    logic [DATA_W-1:0] reg_rd_data;
    logic [3:0]        reg_wr_en;
    logic [DATA_W-1:0] reg_wr_data;
    logic              done;
    logic              flag_z;
    logic              flag_c;

    modport slave (
        input  instr_valid, op, rd, rs, imm, reg_rd_data,
        output instr_ready, reg_rd_en, reg_wr_en, reg_wr_data, done, flag_z, flag_c
    );

    modport master (
        output instr_valid, op, rd, rs, imm, reg_rd_data,
        input  instr_ready, reg_rd_en, reg_wr_en, reg_wr_data, done, flag_z, flag_c
    );
endinterface

// File: rtl/rsc_onehot_dec.sv
// 2-bit register index to 4-bit one-hot select, gated by an enable.
//   idx_i    : register index
//   en_i     : when low the output is all zeros
//   onehot_o : one-hot select (or ONEHOT_NONE)
module rsc_onehot_dec
    import rsc_pkg::*;
(
    input  logic [1:0] idx_i,
    input  logic       en_i,
    output logic [3:0] onehot_o
);
    always_comb begin
        onehot_o = ONEHOT_NONE;
        if (en_i) begin
            unique case (idx_i)
                2'd0: onehot_o = ONEHOT_R0;
                2'd1: onehot_o = ONEHOT_R1;
                2'd2: onehot_o = ONEHOT_R2;
                2'd3: onehot_o = ONEHOT_R3;
            endcase
        end
    end
endmodule

// File: rtl/rsc_reg_xfer_ctrl.sv
// Micro-sequencer in front of the RSC 4-entry register file. Takes one
// MOV/ADDI/SUBI/CLR instruction at a time, reads the source register,
// computes the result and writes the destination register.
//   clk : rising-edge clock
//   rst : synchronous, active-high reset
//   bus : rsc_reg_xfer_ctrl_if.slave (instruction channel + register-file bus)
// Optional build macro RSC_XFER_FLAGS_EN enables the zero/carry flags; without
// it flag_z/flag_c are tied low.
module rsc_reg_xfer_ctrl
    import rsc_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT,
    parameter int unsigned IMM_W  = IMM_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    rsc_reg_xfer_ctrl_if.slave   bus
);
    state_e            state_q, state_d;
    op_e               op_q;
    logic [1:0]        rd_q, rs_q;
    logic [IMM_W-1:0]  imm_q;
    logic [DATA_W-1:0] operand_q;
    logic [DATA_W-1:0] wr_data_q;
    logic [DATA_W:0]   result_d;
    logic [DATA_W:0]   imm_ext;
    logic              accept;

    assign accept  = bus.instr_valid && (state_q == StIdle);
    assign imm_ext = {{(DATA_W + 1 - IMM_W){1'b0}}, imm_q};

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = (op_e'(bus.op) == OP_CLR) ? StExec : StRead;
            StRead:  state_d = StExec;
            StExec:  state_d = StWrite;
            StWrite: state_d = StIdle;
        endcase
    end

    // One extra bit so bit DATA_W is the ADDI carry / SUBI borrow.
    always_comb begin
        result_d = '0;
        unique case (op_q)
            OP_MOV:  result_d = {1'b0, operand_q};
            OP_ADDI: result_d = {1'b0, operand_q} + imm_ext;
            OP_SUBI: result_d = {1'b0, operand_q} - imm_ext;
            OP_CLR:  result_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            op_q      <= OP_MOV;
            rd_q      <= '0;
            rs_q      <= '0;
            imm_q     <= '0;
            operand_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q  <= op_e'(bus.op);
                rd_q  <= bus.rd;
                rs_q  <= bus.rs;
                imm_q <= bus.imm;
            end
            if (state_q == StRead) operand_q <= bus.reg_rd_data;
            if (state_q == StExec) wr_data_q <= result_d[DATA_W-1:0];
        end
    end

`ifdef RSC_XFER_FLAGS_EN
    logic flag_z_q, flag_c_q;
    logic carry_d;

    assign carry_d = ((op_q == OP_ADDI) || (op_q == OP_SUBI)) ? result_d[DATA_W] : 1'b0;

    // Flags capture on the EXEC->WRITE step and hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
        end else if (state_q == StExec) begin
            flag_z_q <= (result_d[DATA_W-1:0] == '0);
            flag_c_q <= carry_d;
        end
    end

    assign bus.flag_z = flag_z_q;
    assign bus.flag_c = flag_c_q;
`else
    logic unused_carry;
    assign unused_carry = result_d[DATA_W];
    assign bus.flag_z   = 1'b0;
    assign bus.flag_c   = 1'b0;
`endif

    // Read and write selects come from mutually exclusive states, so they
    // can never overlap.
    rsc_onehot_dec u_rd_dec (
        .idx_i    (rs_q),
        .en_i     (state_q == StRead),
        .onehot_o (bus.reg_rd_en)
    );

    rsc_onehot_dec u_wr_dec (
        .idx_i    (rd_q),
        .en_i     (state_q == StWrite),
        .onehot_o (bus.reg_wr_en)
    );

    assign bus.instr_ready = (state_q == StIdle);
    assign bus.done        = (state_q == StWrite);
    assign bus.reg_wr_data = wr_data_q;
endmodule
